// File: rtl/usb_pkg.sv
// Shared types for the USB 1.1 receive packet controller: PID codes,
// PID classes, controller states and packet error codes.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    CLS_TOKEN,
    CLS_DATA,
    CLS_HSHK,
    CLS_BAD
  } pid_class_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_TOKEN,
    S_DATA,
    S_HSHK,
    S_FLUSH,
    S_END
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RX       = 3'd1,
    ERR_OVERFLOW = 3'd2,
    ERR_BAD_PID  = 3'd3,
    ERR_LEN      = 3'd4
  } err_t;

  function automatic pid_class_t pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: return CLS_TOKEN;
      PID_DATA0, PID_DATA1:                return CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL:         return CLS_HSHK;
      default:                             return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/usb_holdback.sv
// Two-entry delay line in front of the payload output register. A byte only
// reaches out_data once two younger bytes sit behind it, so the trailing
// CRC16 pair never leaves. flush drops the held bytes and any pending beat.
module usb_holdback (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       flush,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       full,
  output logic       shift_out
);

  logic [1:0] cnt_q, cnt_d;
  logic [7:0] e0_q, e0_d, e1_q, e1_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  assign full      = (cnt_q == 2'd2);
  assign shift_out = push && full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Retire the accepted beat, then shift any new byte through the line.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d       = cnt_q;
    e0_d        = e0_q;
    e1_d        = e1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (flush) begin
      cnt_d       = 2'd0;
      out_valid_d = 1'b0;
    end else if (push) begin
      case (cnt_q)
        2'd0: begin
          e0_d  = push_data;
          cnt_d = 2'd1;
        end
        2'd1: begin
          e1_d  = push_data;
          cnt_d = 2'd2;
        end
        default: begin
          out_data_d  = e0_q;
          out_valid_d = 1'b1;
          e0_d        = e1_q;
          e1_d        = push_data;
        end
      endcase
    end
  end

  // Control state and the visible output beat.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!n_rst) begin
      cnt_q       <= 2'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Held payload bytes.
  always_ff @(posedge clk) begin
    // NOTE: storage entries carry no reset; cnt_q alone says which of them are meaningful.
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level controller behind the usb11 receiver: classifies each packet,
// decodes token fields, streams data payload with CRC16 stripped and issues
// one pkt_done status pulse per packet.
module usb_rx_pkt_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_DATA = 64,
  parameter int CNT_W    = $clog2(MAX_DATA + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rcving,
  input  logic             r_error,
  input  logic [3:0]       PID,
  input  logic             empty,
  input  logic             full,
  input  logic [7:0]       r_data,
  output logic             r_enable,
  input  logic [6:0]       dev_addr,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             tok_valid,
  output logic [3:0]       tok_pid,
  output logic [3:0]       tok_endp,
  output logic             hs_valid,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);

  state_t           state_q, state_d;
  err_t             err_q, err_d, fn_err, err_now;
  logic [3:0]       pid_q, pid_d;
  logic [1:0]       tcnt_q, tcnt_d;
  logic [7:0]       tok0_q, tok0_d;
  logic [2:0]       endp_hi_q, endp_hi_d;
  logic [CNT_W-1:0] pay_q, pay_d, dcnt_q, dcnt_d;
  logic             rcving_q;
  logic             tok_valid_q, tok_valid_d, hs_valid_q, hs_valid_d;
  logic             pkt_done_q, pkt_done_d, pkt_err_q, pkt_err_d;
  logic [3:0]       tok_pid_q, tok_pid_d, tok_endp_q, tok_endp_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             rcv_rise, accept, hb_push, hb_flush, hb_full, hb_shift;

  assign rcv_rise = rcving && !rcving_q;
  assign accept   = data_valid && data_ready;
  assign hb_push  = (state_q == S_DATA) && r_enable;
  assign hb_flush = (state_q != S_DATA) || (err_now != ERR_NONE);

  usb_holdback u_holdback (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (hb_push),
    .push_data (r_data),
    .flush     (hb_flush),
    .out_ready (data_ready),
    .out_data  (data_out),
    .out_valid (data_valid),
    .full      (hb_full),
    .shift_out (hb_shift)
  );

  // FIFO pop strobe; combinational so it can never outrun the empty flag.
  always_comb begin
    r_enable = 1'b0;
    case (state_q)
      S_TOKEN: r_enable = !empty && (tcnt_q != 2'd2);
      S_DATA:  r_enable = !empty && !(data_valid && !data_ready);
      S_FLUSH: r_enable = !empty;
      default: r_enable = 1'b0;
    endcase
  end

  // Packet FSM next state, error arbitration and end-of-packet status.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    pid_d       = pid_q;
    tcnt_d      = tcnt_q;
    tok0_d      = tok0_q;
    endp_hi_d   = endp_hi_q;
    pay_d       = pay_q;
    dcnt_d      = (accept && dcnt_q != MAX_CNT) ? dcnt_q + CNT_W'(1) : dcnt_q;
    tok_valid_d = 1'b0;
    hs_valid_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    tok_pid_d   = tok_pid_q;
    tok_endp_d  = tok_endp_q;
    err_code_d  = err_code_q;
    byte_cnt_d  = byte_cnt_q;
    fn_err      = ERR_NONE;
    err_now     = ERR_NONE;

    case (state_q)
      S_IDLE: if (rcv_rise) state_d = S_CLASSIFY;
      S_CLASSIFY: begin
        err_d  = ERR_NONE;
        tcnt_d = 2'd0;
        pay_d  = '0;
        dcnt_d = '0;
        // PID is stable once a byte is queued or the packet has ended.
        if (!empty || !rcving) begin
          pid_d = PID;
          case (pid_class(PID))
            CLS_TOKEN: state_d = S_TOKEN;
            CLS_DATA:  state_d = S_DATA;
            CLS_HSHK:  state_d = S_HSHK;
            default:   fn_err  = ERR_BAD_PID;
          endcase
        end
      end
      S_TOKEN: begin
        if (r_enable) begin
          if (tcnt_q == 2'd0) tok0_d = r_data;
          else endp_hi_d = r_data[2:0];
          tcnt_d = tcnt_q + 2'd1;
        end else if (!empty) begin
          fn_err = ERR_LEN;
        end else if (!rcving) begin
          if (tcnt_q == 2'd2) state_d = S_END;
          else fn_err = ERR_LEN;
        end
      end
      S_DATA: begin
        if (hb_shift) begin
          if (pay_q == MAX_CNT) fn_err = ERR_LEN;
          else pay_d = pay_q + CNT_W'(1);
        end else if (empty && !rcving) begin
          // The two held bytes are the CRC16; finish once the last beat is taken.
          if (!hb_full) fn_err = ERR_LEN;
          else if (!data_valid || data_ready) state_d = S_END;
        end
      end
      S_HSHK: begin
        if (!empty) fn_err = ERR_LEN;
        else if (!rcving) state_d = S_END;
      end
      S_FLUSH: if (empty && !rcving) state_d = S_END;
      S_END:   state_d = rcv_rise ? S_CLASSIFY : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q inside {S_CLASSIFY, S_TOKEN, S_DATA, S_HSHK}) begin
      if (r_error)             err_now = ERR_RX;
      else if (full && rcving) err_now = ERR_OVERFLOW;
      else                     err_now = fn_err;
    end
    if (err_now != ERR_NONE) begin
      err_d   = err_now;
      state_d = S_FLUSH;
    end

    if (state_d == S_END) begin
      pkt_done_d = 1'b1;
      pkt_err_d  = (err_d != ERR_NONE);
      err_code_d = err_d;
      byte_cnt_d = dcnt_d;
      if (err_d == ERR_NONE) begin
        if (state_q == S_TOKEN) begin
          if (pid_q == PID_SOF || tok0_q[6:0] == dev_addr) begin
            tok_valid_d = 1'b1;
            tok_pid_d   = pid_q;
            tok_endp_d  = {endp_hi_q, tok0_q[7]};
          end
        end else if (state_q == S_HSHK) begin
          hs_valid_d = 1'b1;
          tok_pid_d  = pid_q;
        end
      end
    end
  end

  // State, packet context and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      pid_q       <= 4'h0;
      tcnt_q      <= 2'd0;
      tok0_q      <= 8'h00;
      endp_hi_q   <= 3'd0;
      pay_q       <= '0;
      dcnt_q      <= '0;
      // Treat rcving as already high so a reset mid-packet does not fake a packet start.
      rcving_q    <= 1'b1;
      tok_valid_q <= 1'b0;
      hs_valid_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      tok_pid_q   <= 4'h0;
      tok_endp_q  <= 4'h0;
      err_code_q  <= 3'd0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      pid_q       <= pid_d;
      tcnt_q      <= tcnt_d;
      tok0_q      <= tok0_d;
      endp_hi_q   <= endp_hi_d;
      pay_q       <= pay_d;
      dcnt_q      <= dcnt_d;
      rcving_q    <= rcving;
      tok_valid_q <= tok_valid_d;
      hs_valid_q  <= hs_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      tok_pid_q   <= tok_pid_d;
      tok_endp_q  <= tok_endp_d;
      err_code_q  <= err_code_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign hs_valid  = hs_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign tok_pid   = tok_pid_q;
  assign tok_endp  = tok_endp_q;
  assign err_code  = err_code_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed self-checking bench for usb_rx_pkt_ctrl. A queue models the
// first-word-fall-through receiver FIFO; every packet outcome is compared
// against hand-computed values.
module tb_usb_rx_pkt_ctrl;

  localparam int MAX_DATA = 4;
  localparam int CNT_W    = $clog2(MAX_DATA + 1);

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             rcving = 1'b0;
  logic             r_error = 1'b0;
  logic [3:0]       PID = 4'h0;
  logic             empty = 1'b1;
  logic             full = 1'b0;
  logic [7:0]       r_data = 8'h00;
  logic             r_enable;
  logic [6:0]       dev_addr = 7'h05;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready = 1'b1;
  logic             tok_valid;
  logic [3:0]       tok_pid;
  logic [3:0]       tok_endp;
  logic             hs_valid;
  logic             pkt_done;
  logic             pkt_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] byte_cnt;

  usb_rx_pkt_ctrl #(.MAX_DATA(MAX_DATA), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rcving     (rcving),
    .r_error    (r_error),
    .PID        (PID),
    .empty      (empty),
    .full       (full),
    .r_data     (r_data),
    .r_enable   (r_enable),
    .dev_addr   (dev_addr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tok_valid  (tok_valid),
    .tok_pid    (tok_pid),
    .tok_endp   (tok_endp),
    .hs_valid   (hs_valid),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .err_code   (err_code),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] fifo[$];
  logic [7:0] pkt_q[$];
  logic [7:0] rx[$];
  int         done_cnt = 0;
  int         en_cnt = 0;
  int         viol_empty = 0;
  int         viol_stable = 0;
  int         dv_after = 0;
  logic       armed = 1'b0;
  logic       tog = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_out = 8'h00;
  logic       c_err, c_tokv, c_hsv;
  logic [2:0] c_code;
  logic [3:0] c_tpid, c_tendp;
  logic [CNT_W-1:0] c_bcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void upd();
    empty  = (fifo.size() == 0);
    r_data = empty ? 8'h00 : fifo[0];
  endfunction

  // One clock: observe mid-cycle, pop at the edge, then update FIFO pins.
  task automatic cyc();
    logic       pop;
    logic [7:0] dummy;
    @(negedge clk);
    if (r_enable) en_cnt++;
    if (r_enable && empty) viol_empty++;
    if (prev_stall && data_out !== prev_out) viol_stable++;
    prev_stall = data_valid && !data_ready;
    prev_out   = data_out;
    if (data_valid && data_ready) rx.push_back(data_out);
    if (data_valid && armed) dv_after++;
    if (pkt_done) begin
      done_cnt++;
      c_err   = pkt_err;
      c_code  = err_code;
      c_bcnt  = byte_cnt;
      c_tokv  = tok_valid;
      c_tpid  = tok_pid;
      c_tendp = tok_endp;
      c_hsv   = hs_valid;
    end
    pop = r_enable;
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) dummy = fifo.pop_front();
    upd();
    if (tog) data_ready = !data_ready;
  endtask

  // Deliver one packet of n bytes from pkt_q; r_error pulses with byte err_at.
  task automatic send_pkt(input string tag, input logic [3:0] pid, input int n, input int err_at);
    int d0;
    d0 = done_cnt;
    rx.delete();
    armed    = 1'b0;
    dv_after = 0;
    PID      = pid;
    rcving   = 1'b1;
    cyc();
    for (int i = 0; i < n; i++) begin
      fifo.push_back(pkt_q[i]);
      upd();
      r_error = (i == err_at);
      cyc();
      if (i == err_at) begin
        r_error = 1'b0;
        armed   = 1'b1;
      end
    end
    rcving  = 1'b0;
    r_error = 1'b0;
    for (int k = 0; k < 40 && done_cnt == d0; k++) cyc();
    check({tag, "_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    upd();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_enable", r_enable, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_tok_valid", tok_valid, 0);
    check("rst_tok_pid", tok_pid, 0);
    check("rst_tok_endp", tok_endp, 0);
    check("rst_hs_valid", hs_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    n_rst = 1'b1;
    repeat (6) cyc();
    check("idle_no_pop", en_cnt, 0);
    check("idle_no_done", done_cnt, 0);

    // IN token addr 0x05 endp 3: byte0 = {endp[0], addr}, byte1 = {crc5, endp[3:1]}
    pkt_q = '{8'h85, 8'hA9};
    send_pkt("in", 4'b1001, 2, -1);
    check("in_tok_valid", c_tokv, 1);
    check("in_tok_pid", c_tpid, 4'b1001);
    check("in_tok_endp", c_tendp, 3);
    check("in_pkt_err", c_err, 0);
    check("in_err_code", c_code, 0);

    // Same token, other device
    dev_addr = 7'h06;
    send_pkt("in_miss", 4'b1001, 2, -1);
    check("in_miss_tok_valid", c_tokv, 0);
    check("in_miss_pkt_err", c_err, 0);

    // SOF skips the address check
    pkt_q = '{8'h7F, 8'h00};
    send_pkt("sof", 4'b0101, 2, -1);
    check("sof_tok_valid", c_tokv, 1);
    check("sof_tok_pid", c_tpid, 4'b0101);
    check("sof_pkt_err", c_err, 0);
    dev_addr = 7'h05;

    // DATA0, 4 payload + 2 CRC, downstream ready toggling
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC1, 8'hC2};
    tog = 1'b1;
    data_ready = 1'b0;
    send_pkt("d0", 4'b0011, 6, -1);
    tog = 1'b0;
    data_ready = 1'b1;
    check("d0_pkt_err", c_err, 0);
    check("d0_byte_cnt", c_bcnt, 4);
    check("d0_rx_count", rx.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("d0_byte%0d", i), (i < rx.size()) ? rx[i] : 8'hxx, 8'h11 * (i + 1));

    // Zero-length DATA1: only the CRC16
    pkt_q = '{8'hAB, 8'hCD};
    send_pkt("zlp", 4'b1011, 2, -1);
    check("zlp_pkt_err", c_err, 0);
    check("zlp_byte_cnt", c_bcnt, 0);
    check("zlp_rx_count", rx.size(), 0);

    // ACK, no bytes
    send_pkt("ack", 4'b0010, 0, -1);
    check("ack_hs_valid", c_hsv, 1);
    check("ack_tok_pid", c_tpid, 4'b0010);
    check("ack_tok_valid", c_tokv, 0);
    check("ack_pkt_err", c_err, 0);

    // DATA1 with a single byte is too short
    pkt_q = '{8'h5A};
    send_pkt("short", 4'b1011, 1, -1);
    check("short_pkt_err", c_err, 1);
    check("short_err_code", c_code, 4);
    check("short_rx_count", rx.size(), 0);

    // Undefined PID
    send_pkt("badpid", 4'b0000, 0, -1);
    check("badpid_pkt_err", c_err, 1);
    check("badpid_err_code", c_code, 3);

    // FIFO full while receiving
    pkt_q = '{8'h01, 8'h02, 8'h03};
    full = 1'b1;
    send_pkt("ovf", 4'b0011, 3, -1);
    full = 1'b0;
    check("ovf_pkt_err", c_err, 1);
    check("ovf_err_code", c_code, 2);

    // Payload of MAX_DATA+1 bytes
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC1, 8'hC2};
    send_pkt("long", 4'b0011, 7, -1);
    check("long_pkt_err", c_err, 1);
    check("long_err_code", c_code, 4);
    check("long_max_deliv", rx.size() <= MAX_DATA, 1);

    // r_error in the middle of a DATA0
    pkt_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt("rxerr", 4'b0011, 6, 2);
    check("rxerr_pkt_err", c_err, 1);
    check("rxerr_err_code", c_code, 1);
    check("rxerr_fifo_left", fifo.size(), 0);
    check("rxerr_dv_after", dv_after, 0);
    armed = 1'b0;

    // Reset while a payload beat is stalled
    data_ready = 1'b0;
    PID = 4'b0011;
    rcving = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      fifo.push_back(8'h50 + 8'(i));
      upd();
      cyc();
    end
    check("mid_dv_before", data_valid, 1);
    check("mid_data_before", data_out, 8'h50);
    n_rst = 1'b0;
    prev_stall = 1'b0;
    #1;
    check("mid_rst_dv", data_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_tok_pid", tok_pid, 0);
    check("mid_rst_err_code", err_code, 0);
    check("mid_rst_r_enable", r_enable, 0);
    fifo.delete();
    upd();
    rcving = 1'b0;
    data_ready = 1'b1;
    cyc();
    n_rst = 1'b1;
    repeat (2) cyc();

    // Normal traffic after recovery
    pkt_q = '{8'h85, 8'hA9};
    send_pkt("rec", 4'b1001, 2, -1);
    check("rec_tok_valid", c_tokv, 1);
    check("rec_tok_endp", c_tendp, 3);

    check("never_pop_empty", viol_empty, 0);
    check("stall_data_stable", viol_stable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
# usb_rx_pkt_ctrl

Packet-level controller behind the `usb11` receiver. It watches `rcving`, `PID` and `r_error`, and drains the receiver FIFO through `r_enable`. Each packet is classified as token, data or handshake. Token fields are checked against the device address, and data payload bytes are streamed downstream with the CRC16 stripped. One status pulse is issued per packet.

## Interface
Parameters:
- `MAX_DATA`, 64: maximum payload bytes per data packet, CRC excluded.
- `CNT_W`, `$clog2(MAX_DATA+1)`: width of the byte counter.

Ports:
- `clk` in 1: system clock. One clock domain.
- `n_rst` in 1: reset, asynchronous, active-low.
- `rcving` in 1: receiver is inside a packet.
- `r_error` in 1: receiver error for the current packet.
- `PID` in 4: receiver PID.
- `empty` in 1: receiver FIFO is empty.
- `full` in 1: receiver FIFO is full.
- `r_data` in 8: FIFO head byte, first-word fall-through.
- `r_enable` out 1: FIFO pop.
- `dev_addr` in 7: this device's address.
- `data_out` out 8: payload byte.
- `data_valid` out 1: `data_out` is valid.
- `data_ready` in 1: downstream accepts the byte.
- `tok_valid` out 1: one-cycle token strobe.
- `tok_pid` out 4: token PID.
- `tok_endp` out 4: token endpoint.
- `hs_valid` out 1: one-cycle handshake strobe; `tok_pid` carries the handshake PID.
- `pkt_done` out 1: one-cycle end-of-packet strobe.
- `pkt_err` out 1: qualifies `pkt_done`; the packet was bad.
- `err_code` out 3: error cause, valid with `pkt_done`.
- `byte_cnt` out CNT_W: payload bytes delivered, valid with `pkt_done`.

## Operation
- FIFO contract: `r_data` shows the head whenever `empty`=0. `r_enable` high at a posedge pops one byte. The controller never asserts `r_enable` while `empty`=1.
- PID sampling: `PID` is sampled once per packet, on the first cycle that is either `empty`=0 or the falling edge of `rcving`.
- PID classes:
  - Token: OUT 0001, IN 1001, SOF 0101, SETUP 1101.
  - Data: DATA0 0011, DATA1 1011.
  - Handshake: ACK 0010, NAK 1010, STALL 1110.
  - Any other PID is error `BAD_PID`.
- States and transitions:
  - IDLE: on `rcving` rising, go to CLASSIFY.
  - CLASSIFY: latch PID, then go to TOKEN, DATA or HSHK.
  - TOKEN: pop exactly 2 bytes. Byte0 holds addr[6:0] and endp[0]; byte1[2:0] holds endp[3:1]; byte1[7:3] is CRC5 and is not checked. Then go to END.
  - DATA: pop while `empty`=0, feeding a 2-byte holdback.
    - A byte leaves to `data_out` only when a third byte enters.
    - Pops stall while `data_valid`=1 and `data_ready`=0.
    - On `rcving` falling with FIFO drained, the two held bytes are the CRC16; discard them and go to END.
  - HSHK: wait for `rcving` falling. Any FIFO byte is an error. Then go to END.
  - FLUSH: pop until `empty`=1 and `rcving`=0, then go to END.
  - END: pulse `pkt_done` for one cycle, with `tok_valid` or `hs_valid` as applicable, then go to IDLE.
- Error codes, priority high to low:
  - 1 `RX_ERR`: `r_error` seen at any point in the packet.
  - 2 `OVERFLOW`: `full`=1 while `rcving`=1.
  - 3 `BAD_PID`.
  - 4 `LEN`: token byte count ≠ 2, data bytes < 2 or payload > `MAX_DATA`, or handshake carrying bytes.
  - 0: no error.
- Error handling: the first error goes straight to FLUSH. The holdback is dropped and `pkt_err`=1 at END. `tok_valid`/`hs_valid` are never asserted for an errored packet.
- Address filter: a SOF is reported with no address check. Any other token with addr ≠ `dev_addr` gives `pkt_done`=1, `pkt_err`=0, `tok_valid`=0.
- Byte count: `byte_cnt` counts only the payload bytes handed over. It saturates at `MAX_DATA`.

## Timing
- Reset values: `r_enable`, `data_valid`, `tok_valid`, `hs_valid`, `pkt_done`, `pkt_err` = 0. `data_out`, `tok_pid`, `tok_endp`, `err_code`, `byte_cnt` = 0. State = IDLE.
- Handshake: `data_out` holds stable while `data_valid`=1 and `data_ready`=0. The transfer completes at a posedge with both high.
- Pop-to-output latency: one cycle from the pop that pushes a byte into holdback position 3.
- `pkt_done` comes 1–2 cycles after `rcving` falls with the FIFO empty and the last payload byte accepted.
- Simultaneous pop and falling `rcving`: the pop is processed first.
- Reset mid-packet: every output returns to its reset value and the state is IDLE. Bytes left in the receiver FIFO are flushed on the next `rcving`.
- Back-to-back packets: a `rcving` rise during END is captured and followed by CLASSIFY.

## Structure
- Package `usb_pkg` holds:
  - PID localparams/enum, `pid_class_t` (TOKEN/DATA/HSHK/BAD).
  - `state_t`.
  - `err_t` codes.
- Sub-module `usb_holdback`: 2-entry delay line with push, pop-out, valid and flush.

## Test plan
- Reset, then idle: all outputs 0 and `r_enable` never asserted.
- IN token, addr 0x05, endp 3, `dev_addr`=0x05: `tok_valid`=1, `tok_pid`=1001, `tok_endp`=3, `pkt_done`=1, `pkt_err`=0.
- Same IN token with `dev_addr`=0x06: `pkt_done`=1, `pkt_err`=0, `tok_valid`=0.
- DATA0 carrying 4 payload bytes 0x11,0x22,0x33,0x44 plus 2 CRC bytes, with `data_ready` toggling: exactly those 4 bytes delivered in order, `byte_cnt`=4, `pkt_err`=0.
- ACK with no bytes: `hs_valid`=1, `tok_pid`=0010. DATA1 with only 1 byte: `pkt_err`=1, `err_code`=4.
- DATA0 with `r_error` pulsed mid-stream: FIFO flushed to `empty`, `pkt_err`=1, `err_code`=1, no further `data_valid`.
